// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - multi-outstanding instruction prefetch queue between I$ and decode
module prefetch_queue #(
    parameter int                 XLEN            = 32,
    parameter int                 ADDRW           = 32,
    parameter logic [XLEN-1:0]    PC_RESET_ADDR   = '0,
    parameter int                 FIFO_DEPTH      = 4,
    parameter int                 MAX_OUTSTANDING = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [ADDRW-1:0] imem_addr_o,
    output logic             imem_valid_o,
    input  logic             imem_ready_i,
    input  logic [XLEN-1:0]  imem_rdata_i,
    input  logic             imem_resp_i,
    input  logic             redirect_en_i,
    input  logic [XLEN-1:0]  redirect_addr_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [XLEN-1:0]  instr_o,
    output logic [XLEN-1:0]  pc_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = CW + OW + 1;

    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]   inflight_q, inflight_d;
    logic [OW-1:0]   stale_q, stale_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] mem_instr_q [FIFO_DEPTH];
    logic [XLEN-1:0] mem_pc_q    [FIFO_DEPTH];

    logic [SW-1:0]   credit_used;
    logic [XLEN-1:0] redirect_pc;
    logic            accept;
    logic            resp_dec;
    logic            push;
    logic            pop;
    logic            empty;
    logic            full;

    // Every live in-flight request already owns a queue slot, so a live response can always be stored.
    assign credit_used  = SW'(count_q) + SW'(inflight_q) - SW'(stale_q);
    assign redirect_pc  = redirect_addr_i & ~XLEN'(3);
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(FIFO_DEPTH));

    assign imem_addr_o  = req_pc_q[ADDRW-1:0] & ~ADDRW'(3);
    assign imem_valid_o = rst_ni && !redirect_en_i
                       && (inflight_q < OW'(MAX_OUTSTANDING))
                       && (credit_used < SW'(FIFO_DEPTH));
    assign accept       = imem_valid_o && imem_ready_i;
    assign resp_dec     = imem_resp_i && (inflight_q != '0);
    assign push         = imem_resp_i && (stale_q == '0) && !redirect_en_i;

    assign instr_valid_o = rst_ni && !empty && !redirect_en_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_o       = mem_instr_q[rd_ptr_q];
    assign pc_o          = mem_pc_q[rd_ptr_q];

    always_comb begin
        req_pc_d   = req_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + OW'(accept) - OW'(resp_dec);
        stale_d    = stale_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);

        if (accept) begin
            req_pc_d = req_pc_q + XLEN'(4);
        end
        if (imem_resp_i && (stale_q != '0)) begin
            stale_d = stale_q - OW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            rsp_pc_d = rsp_pc_q + XLEN'(4);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Everything still outstanding after this cycle belongs to the old stream.
        if (redirect_en_i) begin
            req_pc_d   = redirect_pc;
            rsp_pc_d   = redirect_pc;
            inflight_d = inflight_q - OW'(resp_dec);
            stale_d    = inflight_q - OW'(resp_dec);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_pc_q   <= PC_RESET_ADDR;
            rsp_pc_q   <= PC_RESET_ADDR;
            inflight_q <= '0;
            stale_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            req_pc_q   <= req_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            mem_instr_q[wr_ptr_q] <= imem_rdata_i;
            mem_pc_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
    a_stale_le_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni) stale_q <= inflight_q);

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - directed self-checking bench for prefetch_queue
module tb_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_en;
    logic [31:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;

    prefetch_queue dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .imem_addr_o     (imem_addr),
        .imem_valid_o    (imem_valid),
        .imem_ready_i    (imem_ready),
        .imem_rdata_i    (imem_rdata),
        .imem_resp_i     (imem_resp),
        .redirect_en_i   (redirect_en),
        .redirect_addr_i (redirect_addr),
        .instr_valid_o   (instr_valid),
        .instr_ready_i   (instr_ready),
        .instr_o         (instr),
        .pc_o            (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] acc_log[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          acc_cnt = 0;
    int          max_out = 0;
    int          delivered = 0;
    logic [31:0] exp_next = '0;
    logic        saw_zero = 1'b0;
    logic [31:0] a0;
    int          acc_before;

    function automatic logic [31:0] wfn(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample accepts/deliveries away from the edge, then advance the I$ model.
    task automatic tick();
        logic        acc;
        logic        rsp;
        logic [31:0] acc_addr;
        @(negedge clk);
        acc      = imem_valid && imem_ready;
        acc_addr = imem_addr;
        rsp      = imem_resp;
        if (instr_valid && instr_ready) begin
            check("deliver_pc", pc, exp_next);
            check("deliver_instr", instr, wfn(exp_next));
            if (pc == 32'h0 && exp_next == 32'h0) saw_zero = 1'b1;
            exp_next = exp_next + 32'd4;
            delivered++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rsp && pend.size() > 0) void'(pend.pop_front());
        if (acc) begin
            pend.push_back('{due: cyc + lat - 1, addr: acc_addr});
            acc_log.push_back(acc_addr);
            acc_cnt++;
        end
        if (pend.size() > max_out) max_out = pend.size();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp  = 1'b1;
            imem_rdata = wfn(pend[0].addr);
        end else begin
            imem_resp  = 1'b0;
            imem_rdata = '0;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        redirect_en = 1'b0;
        imem_resp   = 1'b0;
        pend.delete();
        repeat (3) tick();
        #1;
        check("rst_imem_valid", 32'(imem_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        rst_n     = 1'b1;
        exp_next  = '0;
        acc_cnt   = 0;
        max_out   = 0;
        delivered = 0;
        acc_log.delete();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = '0; imem_resp = 1'b0;
        redirect_en = 1'b0; redirect_addr = '0; instr_ready = 1'b1;

        // Reset then sequential stream with 1-cycle I$
        lat = 1;
        do_reset();
        check("t1_v0", 32'(imem_valid), 32'd1);
        check("t1_a0", imem_addr, 32'h0);
        tick(); #1;
        check("t1_a1", imem_addr, 32'h4);
        tick(); #1;
        check("t1_a2", imem_addr, 32'h8);
        check("t1_iv", 32'(instr_valid), 32'd1);
        check("t1_pc0", pc, 32'h0);
        check("t1_w0", instr, wfn(32'h0));
        repeat (10) tick();
        check("t1_nogap", 32'(delivered), 32'd10);

        // Backpressure: queue fills with exactly FIFO_DEPTH requests
        instr_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        check("t2_acc4", 32'(acc_cnt), 32'd4);
        #1;
        check("t2_stop", 32'(imem_valid), 32'd0);
        check("t2_iv", 32'(instr_valid), 32'd1);
        check("t2_head", pc, 32'h0);
        instr_ready = 1'b1;
        repeat (12) tick();
        check("t2_resume", acc_log.size() > 4 ? acc_log[4] : 32'hFFFF_FFFF, 32'h10);
        check("t2_drain", 32'(delivered >= 4), 32'd1);

        // Outstanding limit with long I$ latency, then held address
        lat = 5;
        do_reset();
        repeat (40) tick();
        check("t3_maxout", 32'(max_out), 32'd2);
        check("t3_deliv", 32'(delivered > 0), 32'd1);
        imem_ready = 1'b0;
        #1;
        a0 = imem_addr;
        acc_before = acc_cnt;
        repeat (3) tick();
        check("t3_hold", imem_addr, a0);
        check("t3_noacc", 32'(acc_cnt), 32'(acc_before));
        imem_ready = 1'b1;

        // Redirect with two requests in flight
        do_reset();
        for (int i = 0; i < 20 && pend.size() < 2; i++) tick();
        check("t4_two", 32'(pend.size()), 32'd2);
        redirect_en   = 1'b1;
        redirect_addr = 32'h103;
        exp_next      = 32'h100;
        #1;
        check("t4_noreq", 32'(imem_valid), 32'd0);
        check("t4_noiv", 32'(instr_valid), 32'd0);
        tick();
        redirect_en = 1'b0;
        #1;
        check("t4_addr", imem_addr, 32'h100);
        repeat (30) tick();
        check("t4_req3", acc_log.size() > 2 ? acc_log[2] : 32'hFFFF_FFFF, 32'h100);
        check("t4_deliv", 32'(delivered > 0), 32'd1);

        // Redirect coinciding with a response and a would-be pop
        lat = 1;
        do_reset();
        repeat (6) tick();
        #1;
        check("t5_rsp", 32'(imem_resp), 32'd1);
        check("t5_pre_iv", 32'(instr_valid), 32'd1);
        redirect_en   = 1'b1;
        redirect_addr = 32'h200;
        exp_next      = 32'h200;
        #1;
        check("t5_noiv", 32'(instr_valid), 32'd0);
        tick();
        redirect_en = 1'b0;
        #1;
        check("t5_empty", 32'(instr_valid), 32'd0);
        check("t5_req", 32'(imem_valid), 32'd1);
        check("t5_addr", imem_addr, 32'h200);
        acc_before = delivered;
        repeat (8) tick();
        check("t5_deliv", 32'(delivered > acc_before), 32'd1);

        // PC wrap across 2^32
        redirect_en   = 1'b1;
        redirect_addr = 32'hFFFF_FFF8;
        exp_next      = 32'hFFFF_FFF8;
        saw_zero      = 1'b0;
        tick();
        redirect_en = 1'b0;
        repeat (10) tick();
        check("t6_wrap", 32'(saw_zero), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
